// File: rtl/vmax_pool_pkg.sv
// Shared types and helpers for the streaming vertical/horizontal max-pool stage.
// Lanes narrower than data_t are sign-extended into smax by the users.
package vmax_pool_pkg;

   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_SA_LENGTH       = 256;
   localparam int DEF_MAX_FILTER_SIZE = 7;
   localparam int K_W = $clog2(DEF_MAX_FILTER_SIZE + 1);

   typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;
   typedef data_t row_t [DEF_SA_LENGTH];

   typedef enum logic {IDLE, ACCUM} state_t;

   function automatic data_t smax(data_t a, data_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vmax_pool_stream_hmax.sv
// Horizontal compaction: every K grouping is built, then selected by kr_i.
// Group j covers lanes K*j..K*j+K-1; groups starting past the row are masked.
module hmax_group_reduce
   import vmax_pool_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int SA_LENGTH       = DEF_SA_LENGTH,
   parameter int MAX_FILTER_SIZE = DEF_MAX_FILTER_SIZE,
   localparam int KW = $clog2(MAX_FILTER_SIZE + 1)
) (
   input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] row_i,
   input  logic [KW-1:0]                        kr_i,
   output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] pool_o,
   output logic [SA_LENGTH-1:0]                 mask_o
);

   typedef logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] prow_t;

   function automatic logic [DATA_WIDTH-1:0] lmax(
      logic [DATA_WIDTH-1:0] a,
      logic [DATA_WIDTH-1:0] b
   );
      return DATA_WIDTH'(smax(data_t'($signed(a)),
                              data_t'($signed(b))));
   endfunction

   prow_t                              cand  [1:MAX_FILTER_SIZE];
   logic [SA_LENGTH-1:0]               cmask [1:MAX_FILTER_SIZE];

   always_comb begin
      for (int k = 1; k <= MAX_FILTER_SIZE; k++) begin
         cand[k]  = '0;
         cmask[k] = '0;
         for (int j = 0; j < SA_LENGTH; j++) begin
            if (k * j < SA_LENGTH) begin
               cmask[k][j] = 1'b1;
               cand[k][j]  = row_i[k*j];
               for (int i = 1; i < k; i++) begin
                  if (k * j + i < SA_LENGTH)
                     cand[k][j] = lmax(cand[k][j], row_i[k*j+i]);
               end
            end
         end
      end
   end

   always_comb begin
      pool_o = '0;
      mask_o = '0;
      for (int k = 1; k <= MAX_FILTER_SIZE; k++) begin
         if (int'(kr_i) == k) begin
            pool_o = cand[k];
            mask_o = cmask[k];
         end
      end
   end

endmodule

// File: rtl/vmax_pool_stream.sv
// Streaming max-pool: per-lane running vertical max over K rows, then
// horizontal compaction in groups of K into a registered output beat.
module vmax_pool_stream
   import vmax_pool_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int SA_LENGTH       = DEF_SA_LENGTH,
   parameter int MAX_FILTER_SIZE = DEF_MAX_FILTER_SIZE,
   localparam int KW = $clog2(MAX_FILTER_SIZE + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [KW-1:0]                        cfg_k,
   output logic                                 busy,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 in_last,
   input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic [SA_LENGTH-1:0]                 out_mask,
   output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] out_data
);

   typedef logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] prow_t;

   function automatic logic [DATA_WIDTH-1:0] lmax(
      logic [DATA_WIDTH-1:0] a,
      logic [DATA_WIDTH-1:0] b
   );
      return DATA_WIDTH'(smax(data_t'($signed(a)),
                              data_t'($signed(b))));
   endfunction

   state_t               state_q;
   logic [KW-1:0]        kr_q, kr_d;
   logic [KW-1:0]        row_cnt_q;
   prow_t                acc_q, acc_d;
   logic                 out_valid_q;
   logic                 out_last_q;
   logic [SA_LENGTH-1:0] out_mask_q;
   prow_t                out_data_q;
   prow_t                pool;
   logic [SA_LENGTH-1:0] pmask;
   logic                 accept, close_win;

   always_comb begin
      kr_d = cfg_k;
      if (cfg_k == '0)
         kr_d = KW'(1);
      else if (int'(cfg_k) > MAX_FILTER_SIZE)
         kr_d = KW'(MAX_FILTER_SIZE);
   end

   assign in_ready  = (state_q == ACCUM) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign close_win = accept &&
                      (in_last || row_cnt_q == kr_q - KW'(1));

   // First row of a window overwrites; zero is never a valid seed.
   always_comb begin
      for (int l = 0; l < SA_LENGTH; l++)
         acc_d[l] = (row_cnt_q == '0) ? in_data[l]
                                      : lmax(acc_q[l], in_data[l]);
   end

   hmax_group_reduce #(
      .DATA_WIDTH      (DATA_WIDTH),
      .SA_LENGTH       (SA_LENGTH),
      .MAX_FILTER_SIZE (MAX_FILTER_SIZE)
   ) u_hmax (
      .row_i  (acc_d),
      .kr_i   (kr_q),
      .pool_o (pool),
      .mask_o (pmask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         kr_q        <= KW'(1);
         row_cnt_q   <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_mask_q  <= '0;
         out_data_q  <= '0;
      end else begin
         if (out_valid_q && out_ready)
            out_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  kr_q      <= kr_d;
                  row_cnt_q <= '0;
                  state_q   <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  if (close_win) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= pool;
                     out_mask_q  <= pmask;
                     out_last_q  <= in_last;
                     row_cnt_q   <= '0;
                     if (in_last)
                        state_q <= IDLE;
                  end else begin
                     row_cnt_q <= row_cnt_q + KW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_mask  = out_mask_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_vmax_pool_stream.sv
// Scoreboard bench for vmax_pool_stream at DATA_WIDTH=8, SA_LENGTH=8,
// MAX_FILTER_SIZE=4; expected beats are queued as stimulus is driven.
module tb_vmax_pool_stream;

   localparam int DW = 8;
   localparam int SA = 8;
   localparam int MF = 4;
   localparam int KW = 3;

   typedef logic [SA-1:0][DW-1:0] row_t;
   typedef struct packed {
      row_t          data;
      logic [SA-1:0] mask;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [KW-1:0] cfg_k;
   logic          busy;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   row_t          in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [SA-1:0] out_mask;
   row_t          out_data;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   vmax_pool_stream #(
      .DATA_WIDTH      (DW),
      .SA_LENGTH       (SA),
      .MAX_FILTER_SIZE (MF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_k     (cfg_k),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_mask  (out_mask),
      .out_data  (out_data)
   );

   function automatic row_t mk(input int a[SA]);
      row_t r;
      for (int i = 0; i < SA; i++) r[i] = DW'(a[i]);
      return r;
   endfunction

   function automatic row_t rnd_row();
      row_t r;
      for (int i = 0; i < SA; i++) r[i] = DW'($urandom);
      return r;
   endfunction

   function automatic row_t vmax(row_t a, row_t b);
      row_t r;
      for (int i = 0; i < SA; i++)
         r[i] = ($signed(a[i]) > $signed(b[i])) ? a[i] : b[i];
      return r;
   endfunction

   function automatic exp_t hpool(row_t v, int k, logic last);
      exp_t e;
      logic signed [DW-1:0] m;
      e = '0;
      e.last = last;
      for (int j = 0; j < SA; j++) begin
         if (k * j < SA) begin
            e.mask[j] = 1'b1;
            m = $signed(v[k*j]);
            for (int i = 1; i < k; i++)
               if (k * j + i < SA && $signed(v[k*j+i]) > m)
                  m = $signed(v[k*j+i]);
            e.data[j] = m;
         end
      end
      return e;
   endfunction

   task automatic sb_monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected data=%h mask=%h last=%b required none",
                        out_data, out_mask, out_last);
            end else begin
               e = sbq.pop_front();
               if ({out_data, out_mask, out_last} !== e) begin
                  n_fail++;
                  $display("FAIL sb_beat data=%h mask=%h last=%b required data=%h mask=%h last=%b",
                           out_data, out_mask, out_last, e.data, e.mask, e.last);
               end
            end
         end
      end
   endtask

   task automatic start_map(int k);
      @(posedge clk); #1;
      cfg_k = KW'(k);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_row(row_t d, logic last);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_row_timeout in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required 0", sbq.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if ({busy, in_ready, out_valid, out_last} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl busy/ird/ov/ol=%b required 0000",
                  {busy, in_ready, out_valid, out_last});
      end
      n_checks++;
      if (out_mask !== '0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_out mask=%h data=%h required 0",
                  out_mask, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = rnd_row();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignore ird=%b ov=%b busy=%b required 0 0 0",
                  in_ready, out_valid, busy);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_basic_k2();
      exp_t e;
      start_map(2);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL k2_busy busy=%b required 1", busy);
      end
      e.data = mk('{8, 6, 6, 8, 0, 0, 0, 0});
      e.mask = 8'h0F;
      e.last = 1'b1;
      sbq.push_back(e);
      send_row(mk('{1, 2, 3, 4, 5, 6, 7, 8}), 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL k2_early ov=%b required 0", out_valid);
      end
      send_row(mk('{8, 7, 6, 5, 4, 3, 2, 1}), 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL k2_latency ov=%b busy=%b required 1 0",
                  out_valid, busy);
      end
      drain();
   endtask

   task automatic test_all_negative();
      exp_t e;
      start_map(3);
      e.data = mk('{-5, -5, -5, 0, 0, 0, 0, 0});
      e.mask = 8'h07;
      e.last = 1'b1;
      sbq.push_back(e);
      for (int r = 0; r < 3; r++)
         send_row(mk('{-5, -5, -5, -5, -5, -5, -5, -5}), r == 2);
      drain();
   endtask

   task automatic test_partial();
      exp_t e;
      start_map(3);
      e.data = mk('{9, 3, 4, 0, 0, 0, 0, 0});
      e.mask = 8'h07;
      e.last = 1'b1;
      sbq.push_back(e);
      send_row(mk('{0, 9, -1, 2, -7, 3, 4, -2}), 1'b1);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_emit ov=%b required 1", out_valid);
      end
      drain();
   endtask

   task automatic test_backpressure();
      row_t rows[4];
      int   t;
      out_ready = 1'b0;
      start_map(1);
      for (int i = 0; i < 4; i++) begin
         rows[i] = rnd_row();
         sbq.push_back(hpool(rows[i], 1, i == 3));
      end
      fork
         begin
            for (int i = 0; i < 4; i++) send_row(rows[i], i == 3);
         end
         begin
            t = 0;
            while (!out_valid && t < 20) begin
               @(negedge clk);
               t++;
            end
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               n_checks++;
               if (in_ready !== 1'b0 || out_data !== rows[0]) begin
                  n_fail++;
                  $display("FAIL bp_hold ird=%b data=%h required 0 %h",
                           in_ready, out_data, rows[0]);
               end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
   endtask

   task automatic test_clamp();
      row_t r0, r1, v;
      exp_t e;
      start_map(0);
      r0 = rnd_row();
      r1 = rnd_row();
      sbq.push_back(hpool(r0, 1, 1'b0));
      sbq.push_back(hpool(r1, 1, 1'b1));
      send_row(r0, 1'b0);
      send_row(r1, 1'b1);
      drain();
      start_map(7);
      v = rnd_row();
      send_row(v, 1'b0);
      start_map(1);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clamp_midstart busy=%b required 1", busy);
      end
      for (int i = 1; i < 4; i++) begin
         r0 = rnd_row();
         v  = vmax(v, r0);
         if (i == 3) begin
            e = hpool(v, 4, 1'b1);
            n_checks++;
            if (e.mask !== 8'h03) begin
               n_fail++;
               $display("FAIL clamp_model mask=%h required 03", e.mask);
            end
            sbq.push_back(e);
         end
         send_row(r0, i == 3);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      start_map(4);
      send_row(rnd_row(), 1'b0);
      send_row(rnd_row(), 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, in_ready, out_valid, out_last} !== 4'b0 ||
          out_mask !== '0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL rst_mid busy=%b ird=%b ov=%b mask=%h data=%h required 0",
                  busy, in_ready, out_valid, out_mask, out_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_emit ov=%b busy=%b required 0 0",
                     out_valid, busy);
         end
      end
      @(posedge clk); #1;
      test_basic_k2();
   endtask

   task automatic test_random_stream();
      bit   done;
      int   nrows, cnt;
      row_t r, v;
      logic last;
      for (int k = 1; k <= MF; k++) begin
         done  = 1'b0;
         nrows = $urandom_range(9, 5);
         start_map(k);
         fork
            begin
               cnt = 0;
               v   = '0;
               for (int i = 0; i < nrows; i++) begin
                  r    = rnd_row();
                  last = (i == nrows - 1);
                  v    = (cnt == 0) ? r : vmax(v, r);
                  if (cnt == k - 1 || last) begin
                     sbq.push_back(hpool(v, k, last));
                     cnt = 0;
                  end else begin
                     cnt++;
                  end
                  send_row(r, last);
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  @(posedge clk); #1;
                  out_ready = 1'($urandom % 2);
               end
            end
         join
         out_ready = 1'b1;
         drain();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      cfg_k     = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      fork
         sb_monitor();
         begin
            #200000;
            $display("FAIL watchdog timeout");
            $fatal(1, "watchdog");
         end
      join_none
      test_reset();
      test_basic_k2();
      test_all_negative();
      test_partial();
      test_backpressure();
      test_clamp();
      test_reset_mid();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
